// File: rtl/pal_csync_generator_if.sv
// Sync-generator bus: timing control inputs and the generated PAL sync outputs.
// The generator side uses the master modport; a sync consumer uses slave.
interface pal_csync_generator_if;
    logic       enable;
    logic       frame_sync;
    logic       csync;
    logic       hsync;
    logic       vsync;
    logic       odd_field;
    logic [9:0] line_number;

    modport master (
        input  enable, frame_sync,
        output csync, hsync, vsync, odd_field, line_number
    );

    modport slave (
        output enable, frame_sync,
        input  csync, hsync, vsync, odd_field, line_number
    );
endinterface

// File: rtl/pal_csync_generator.sv
// PAL 625-line interlaced composite sync generator built from half-line slots.
// All outputs are registered from the current (h, pix) position.
module pal_csync_generator #(
    parameter int HALF_LINE = 2592,
    parameter int HSYNC_LEN = 381,
    parameter int EQ_LEN    = 190,
    parameter int BROAD_LEN = 2211
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pal_csync_generator_if.master bus
);
    localparam int              PIX_W    = $clog2(HALF_LINE);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(HALF_LINE - 1);
    localparam logic [PIX_W-1:0] PIX_ZERO = PIX_W'(0);
    localparam logic [10:0]     H_LAST   = 11'd1249;
    localparam logic [10:0]     H_FIELD2 = 11'd625;

    typedef enum logic [1:0] {
        SLOT_NONE  = 2'd0,
        SLOT_HSYNC = 2'd1,
        SLOT_EQ    = 2'd2,
        SLOT_BROAD = 2'd3
    } slot_e;

    function automatic slot_e slot_of(input logic [10:0] h);
        slot_e s;
        if (h <= 11'd4)         s = SLOT_BROAD;
        else if (h <= 11'd9)    s = SLOT_EQ;
        else if (h <= 11'd619)  s = h[0] ? SLOT_NONE : SLOT_HSYNC;
        else if (h <= 11'd624)  s = SLOT_EQ;
        else if (h <= 11'd629)  s = SLOT_BROAD;
        else if (h <= 11'd634)  s = SLOT_EQ;
        else if (h == 11'd635)  s = SLOT_NONE;
        else if (h <= 11'd1244) s = h[0] ? SLOT_NONE : SLOT_HSYNC;
        else                    s = SLOT_EQ;
        return s;
    endfunction

    function automatic logic [PIX_W-1:0] pulse_len(input slot_e s);
        logic [PIX_W-1:0] len;
        case (s)
            SLOT_BROAD: len = PIX_W'(BROAD_LEN);
            SLOT_EQ:    len = PIX_W'(EQ_LEN);
            SLOT_HSYNC: len = PIX_W'(HSYNC_LEN);
            default:    len = PIX_ZERO;
        endcase
        return len;
    endfunction

    logic [PIX_W-1:0] pix_r, pix_nxt_s;
    logic [10:0]      h_r, h_nxt_s;
    logic             csync_r, hsync_r, vsync_r, odd_field_r;
    logic [9:0]       line_number_r;
    logic             csync_nxt_s, hsync_nxt_s, vsync_nxt_s, odd_field_nxt_s;
    logic [9:0]       line_number_nxt_s;
    logic             line_start_s;

    // Position register update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_r <= PIX_ZERO;
            h_r   <= 11'd0;
        end else begin
            pix_r <= pix_nxt_s;
            h_r   <= h_nxt_s;
        end
    end

    // Next position: frame_sync restarts even while disabled.
    always_comb begin
        pix_nxt_s = pix_r;
        h_nxt_s   = h_r;
        if (bus.frame_sync) begin
            pix_nxt_s = PIX_ZERO;
            h_nxt_s   = 11'd0;
        end else if (bus.enable) begin
            if (pix_r == PIX_LAST) begin
                pix_nxt_s = PIX_ZERO;
                h_nxt_s   = (h_r == H_LAST) ? 11'd0 : h_r + 11'd1;
            end else begin
                pix_nxt_s = pix_r + PIX_W'(1);
                h_nxt_s   = h_r;
            end
        end else begin
            pix_nxt_s = pix_r;
            h_nxt_s   = h_r;
        end
    end

    // Output decode from the current position; disabled forces syncs inactive.
    always_comb begin
        line_start_s      = (pix_r == PIX_ZERO);
        csync_nxt_s       = 1'b1;
        hsync_nxt_s       = 1'b0;
        vsync_nxt_s       = 1'b0;
        odd_field_nxt_s   = odd_field_r;
        line_number_nxt_s = line_number_r;
        if (bus.enable) begin
            csync_nxt_s       = !(pix_r < pulse_len(slot_of(h_r)));
            hsync_nxt_s       = line_start_s && !h_r[0];
            vsync_nxt_s       = line_start_s && ((h_r == 11'd0) || (h_r == H_FIELD2));
            odd_field_nxt_s   = (h_r < H_FIELD2);
            line_number_nxt_s = h_r[10:1] + 10'd1;
        end else begin
            csync_nxt_s       = 1'b1;
            hsync_nxt_s       = 1'b0;
            vsync_nxt_s       = 1'b0;
            odd_field_nxt_s   = odd_field_r;
            line_number_nxt_s = line_number_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csync_r       <= 1'b1;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            odd_field_r   <= 1'b1;
            line_number_r <= 10'd1;
        end else begin
            csync_r       <= csync_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            odd_field_r   <= odd_field_nxt_s;
            line_number_r <= line_number_nxt_s;
        end
    end

    assign bus.csync       = csync_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.odd_field   = odd_field_r;
    assign bus.line_number = line_number_r;
endmodule

// File: tb/tb_pal_csync_generator.sv
// Randomized bench for pal_csync_generator: a full-timing instance and a
// shortened-timing instance share stimulus and are checked every cycle.
module tb_pal_csync_generator;
    localparam int S_HALF = 24;
    localparam int S_HS   = 4;
    localparam int S_EQ   = 2;
    localparam int S_BR   = 20;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic frame_sync;

    always #5 clk = ~clk;

    pal_csync_generator_if bus_full();
    pal_csync_generator_if bus_small();

    assign bus_full.enable      = enable;
    assign bus_full.frame_sync  = frame_sync;
    assign bus_small.enable     = enable;
    assign bus_small.frame_sync = frame_sync;

    pal_csync_generator u_dut_full (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_full)
    );

    pal_csync_generator #(
        .HALF_LINE (S_HALF),
        .HSYNC_LEN (S_HS),
        .EQ_LEN    (S_EQ),
        .BROAD_LEN (S_BR)
    ) u_dut_small (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_small)
    );

    int half_len[2]  = '{2592, S_HALF};
    int hsync_len[2] = '{381, S_HS};
    int eq_len[2]    = '{190, S_EQ};
    int broad_len[2] = '{2211, S_BR};

    int   m_h[2];
    int   m_pix[2];
    logic e_csync[2];
    logic e_hsync[2];
    logic e_vsync[2];
    logic e_odd[2];
    int   e_line[2];

    int tests = 0;
    int fails = 0;
    int hold_left = 0;

    // Each field starts with 5 broad and 5 equalising half-lines and ends with 5
    // equalising ones; between them even half-lines carry a line sync.
    function automatic int low_len(input int h, input int i);
        int k;
        k = h % 625;
        if (k < 5) return broad_len[i];
        if (k < 10 || k >= 620) return eq_len[i];
        if (h % 2 == 0) return hsync_len[i];
        return 0;
    endfunction

    task automatic model_step(input int i);
        if (!reset_n) begin
            m_h[i] = 0; m_pix[i] = 0;
            e_csync[i] = 1'b1; e_hsync[i] = 1'b0; e_vsync[i] = 1'b0;
            e_odd[i] = 1'b1; e_line[i] = 1;
        end else begin
            if (enable) begin
                e_csync[i] = !(m_pix[i] < low_len(m_h[i], i));
                e_hsync[i] = (m_pix[i] == 0) && (m_h[i] % 2 == 0);
                e_vsync[i] = (m_pix[i] == 0) && (m_h[i] == 0 || m_h[i] == 625);
                e_odd[i]   = (m_h[i] < 625);
                e_line[i]  = m_h[i] / 2 + 1;
            end else begin
                e_csync[i] = 1'b1; e_hsync[i] = 1'b0; e_vsync[i] = 1'b0;
            end
            if (frame_sync) begin
                m_h[i] = 0; m_pix[i] = 0;
            end else if (enable) begin
                m_pix[i] = m_pix[i] + 1;
                if (m_pix[i] == half_len[i]) begin
                    m_pix[i] = 0;
                    m_h[i] = (m_h[i] + 1) % 1250;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, actual, expected);
        end
    endtask

    task automatic compare_all();
        check("full.csync",  {31'd0, bus_full.csync},     {31'd0, e_csync[0]});
        check("full.hsync",  {31'd0, bus_full.hsync},     {31'd0, e_hsync[0]});
        check("full.vsync",  {31'd0, bus_full.vsync},     {31'd0, e_vsync[0]});
        check("full.odd",    {31'd0, bus_full.odd_field}, {31'd0, e_odd[0]});
        check("full.line",   {22'd0, bus_full.line_number}, e_line[0]);
        check("small.csync", {31'd0, bus_small.csync},     {31'd0, e_csync[1]});
        check("small.hsync", {31'd0, bus_small.hsync},     {31'd0, e_hsync[1]});
        check("small.vsync", {31'd0, bus_small.vsync},     {31'd0, e_vsync[1]});
        check("small.odd",   {31'd0, bus_small.odd_field}, {31'd0, e_odd[1]});
        check("small.line",  {22'd0, bus_small.line_number}, e_line[1]);
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_random(input bit wild);
        frame_sync = 1'b0;
        reset_n    = 1'b1;
        if (hold_left > 0) begin
            enable = 1'b0;
            hold_left--;
        end else begin
            enable = 1'b1;
            if ($urandom_range(0, wild ? 799 : 3999) == 0)
                hold_left = $urandom_range(1, 500);
        end
        if (wild) begin
            if ($urandom_range(0, 1999) == 0) frame_sync = 1'b1;
            if ($urandom_range(0, 4999) == 0) reset_n = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; frame_sync = 1'b0;
        repeat (4) run_cycle();
        reset_n = 1'b1; enable = 1'b1;
        // Long clean run: the short instance covers a whole frame and its wrap.
        for (int c = 0; c < 34000; c++) begin
            run_cycle();
            drive_random(1'b0);
        end
        hold_left = 0;
        enable = 1'b0; frame_sync = 1'b1;
        run_cycle();
        frame_sync = 1'b0;
        repeat (3) run_cycle();
        enable = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            run_cycle();
            drive_random(1'b1);
        end
        run_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
